serial_add_arbiter: RTL and testbench

SERIAL_ADD_ARBITER -- requirements
Module: serial_add_arbiter

---
 rtl/serial_add_arbiter.sv | 112 +++++++++++
 tb/tb_serial_add_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester adder sharing one bit-serial full adder, round-robin arbitrated.
// Latency: result presented WIDTH+1 cycles after the accept cycle, held until taken.
// Backpressure: DONE holds until out_ready; no request is accepted outside IDLE.
module serial_add_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_id,
    output logic             busy
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last_grant;

    logic             win;
    logic [1:0]       grant;
    logic             accept;
    logic             bit_a;
    logic             bit_b;
    logic             fa_s;
    logic             fa_c;
    logic             last_bit;

    // last_grant resets to 1 so that a tie straight out of reset goes to requester 0
    always_comb begin
        win = 1'b0;
        case (req_valid)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_grant;
            default: win = 1'b0;
        endcase
    end

    assign grant     = (state == S_IDLE && !rst) ? (req_valid & (win ? 2'b10 : 2'b01)) : 2'b00;
    assign req_ready = grant;
    assign accept    = |grant;

    assign bit_a    = op_a[idx];
    assign bit_b    = op_b[idx];
    assign fa_s     = bit_a ^ bit_b ^ carry;
    assign fa_c     = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));
    assign last_bit = (idx == IW'(WIDTH - 1));

    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
            sum        <= '0;
            cout       <= 1'b0;
            out_id     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a       <= win ? a1 : a0;
                        op_b       <= win ? b1 : b0;
                        out_id     <= win;
                        last_grant <= win;
                        carry      <= 1'b0;
                        idx        <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum[idx] <= fa_s;
                    carry    <= fa_c;
                    idx      <= idx + IW'(1);
                    if (last_bit) begin
                        cout  <= fa_c;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: vector table plus hand-written reset/backpressure/contention sequences.
module tb_serial_add_arbiter;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] a0, b0, a1, b1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_id;
    logic         busy;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .out_id    (out_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    typedef struct {
        logic [1:0]   rv;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        logic         eid;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[7];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t add_model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] t;
        exp_t e;
        t      = {1'b0, a} + {1'b0, b};
        e.id   = id;
        e.cout = t[W];
        e.sum  = t[W-1:0];
        return e;
    endfunction

    // Presents a request, checks the grant, records the expectation, and steps past the accept edge.
    task automatic do_accept(input logic [1:0] rv, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                             input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic ei,
                             input logic [W-1:0] es, input logic ec, input string tag);
        int   n;
        exp_t e;
        req_valid = rv;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_grant"}, req_ready, ei ? 2'b10 : 2'b01);
        if (req_ready != 2'b00) begin
            e.id = ei; e.cout = ec; e.sum = es;
            sb.push_back(e);
        end
        @(negedge clk);
        #1;
        chk({tag, "_busy_after_accept"}, busy, 1);
        chk({tag, "_ready_after_accept"}, req_ready, 0);
    endtask

    // Waits for the result with out_ready high, checking latency and payload against the scoreboard.
    task automatic wait_result(input string tag);
        int   c;
        int   bad;
        exp_t e;
        c   = 1;
        bad = 0;
        while (!out_valid && c < 40) begin
            if (req_ready != 2'b00) bad++;
            @(negedge clk);
            #1;
            c++;
        end
        chk({tag, "_latency"}, c, W + 1);
        chk({tag, "_ready_while_busy"}, bad, 0);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"}, sum, e.sum);
            chk({tag, "_cout"}, cout, e.cout);
            chk({tag, "_out_id"}, out_id, e.id);
        end
        @(negedge clk);
        #1;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   bad;
        logic ei;

        tbl[0] = '{2'b01, 4'h3, 4'h5, 4'h0, 4'h0, 1'b0, 4'h8, 1'b0};
        tbl[1] = '{2'b10, 4'h0, 4'h0, 4'hF, 4'h1, 1'b1, 4'h0, 1'b1};
        tbl[2] = '{2'b01, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 4'hE, 1'b1};
        tbl[3] = '{2'b11, 4'h2, 4'h4, 4'h7, 4'h8, 1'b1, 4'hF, 1'b0};
        tbl[4] = '{2'b11, 4'h9, 4'h9, 4'h1, 4'h1, 1'b0, 4'h2, 1'b1};
        tbl[5] = '{2'b10, 4'h0, 4'h0, 4'hA, 4'h6, 1'b1, 4'h0, 1'b1};
        tbl[6] = '{2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

        rst = 1'b1; req_valid = 2'b11; out_ready = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_out_id", out_id, 0);
        rst = 1'b0;

        // Contention from reset: both held high, grants alternate starting with requester 0.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] xa0, xb0, xa1, xb1;
            xa0 = W'(i + 1); xb0 = W'(4'hD);
            xa1 = W'(i + 8); xb1 = W'(4'h3);
            ei  = i[0];
            e   = ei ? add_model(1'b1, xa1, xb1) : add_model(1'b0, xa0, xb0);
            do_accept(2'b11, xa0, xb0, xa1, xb1, ei, e.sum, e.cout, $sformatf("rr%0d", i));
            wait_result($sformatf("rr%0d", i));
        end
        req_valid = 2'b00;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_accept(tbl[i].rv, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
                      tbl[i].eid, tbl[i].esum, tbl[i].ecout, $sformatf("vec%0d", i));
            req_valid = 2'b00;
            a0 = '1; b0 = '1; a1 = '1; b1 = '1;
            wait_result($sformatf("vec%0d", i));
        end

        // Backpressure: result must hold while out_ready is low, pending request stays blocked.
        out_ready = 1'b0;
        do_accept(2'b01, 4'h6, 4'h7, 4'h0, 4'h0, 1'b0, 4'hD, 1'b0, "bp");
        req_valid = 2'b10; a1 = 4'h1; b1 = 4'h2;
        bad = 0;
        for (int n = 0; n < 40 && !out_valid; n++) begin
            @(negedge clk);
            #1;
        end
        chk("bp_valid", out_valid, 1);
        for (int n = 0; n < 3; n++) begin
            if (out_valid !== 1'b1 || sum !== 4'hD || cout !== 1'b0 || out_id !== 1'b0 ||
                req_ready !== 2'b00) bad++;
            @(negedge clk);
            #1;
        end
        chk("bp_hold", bad, 0);
        chk("bp_sb_size", sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("bp_sum", sum, e.sum);
            chk("bp_out_id", out_id, e.id);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", req_ready, 2'b10);
        do_accept(2'b10, 4'h0, 4'h0, 4'h1, 4'h2, 1'b1, 4'h3, 1'b0, "bp_next");
        req_valid = 2'b00;
        wait_result("bp_next");

        // Reset mid-RUN discards the transaction and restores the round-robin pointer.
        do_accept(2'b01, 4'h7, 4'h9, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1, "mid");
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        rst = 1'b0;
        req_valid = 2'b00;
        bad = 0;
        for (int n = 0; n < 8; n++) begin
            if (out_valid || busy) bad++;
            @(negedge clk);
            #1;
        end
        chk("mid_no_output", bad, 0);
        do_accept(2'b11, 4'h1, 4'h1, 4'h5, 4'h5, 1'b0, 4'h2, 1'b0, "post_rst");
        req_valid = 2'b00;
        wait_result("post_rst");

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
